secant_search: RTL and testbench
================================

Name: secant_search

Overview:
- Parametrised successor to the single-shot secant current controller.
- Drives the current reference `i_ref` toward the point where the measured plant quantity `measured_q` equals `desired_q`.
- Uses secant iterations with an explicit measurement handshake, a multi-cycle signed divider, clamping, an iteration limit and done/converged/fail status.
- Sits between the control sequencer, which supplies the setpoint and start, and the current DAC/plant-measurement path.

Parameters:
- WIDTH, 10: bit width of `i_ref`, `desired_q`, `measured_q` and the bounds.
- TOL, 30: convergence tolerance. A point has converged when |measured_q − desired_q| < TOL.
- MAX_ITER, 8: maximum secant updates before declaring failure.
- ITW, 4: width of `iter_count`. Must satisfy 2**ITW > MAX_ITER.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a search. Ignored while busy=1.
- desired_q  in  WIDTH  target measurement, unsigned. Sampled on start.
- init_a  in  WIDTH  first bracket/start point, unsigned. Sampled on start.
- init_b  in  WIDTH  second start point, unsigned. Sampled on start.
- measured_q  in  WIDTH  plant measurement, unsigned. Valid only when meas_valid=1.
- meas_valid  in  1  measurement for the current i_ref is available.
- i_ref  out  WIDTH  current reference to the plant.
- ref_valid  out  1  one-cycle pulse: new i_ref applied, measurement requested.
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse at search end.
- converged  out  1  last search met TOL. Held until next start.
- fail  out  1  last search did not converge. Held until next start.
- iter_count  out  ITW  secant updates performed in the last/current search.

Behaviour:
- Reset values (asynchronous, rst=0): i_ref=0, ref_valid=0, busy=0, done=0, converged=0, fail=0, iter_count=0, FSM=IDLE, all internal registers 0.
- Error signal: e = measured_q − desired_q, computed at WIDTH+1 bits signed.
- States:
  - IDLE: on start, capture desired_q, a=init_a, b=init_b. Set busy=1; clear converged, fail and iter_count. Go to SET_A.
  - SET_A: i_ref<=a, ref_valid=1 for one cycle. Go to WAIT_A.
  - WAIT_A: wait for meas_valid; on it, f_a<=e. Go to SET_B.
  - SET_B and WAIT_B: same as SET_A/WAIT_A, with b and f_b.
  - CHECK: if |f_b|<TOL, go to FINISH with converged. Else if iter_count==MAX_ITER, go to FINISH with fail. Else go to DIV.
  - DIV: compute q = f_b*(b−a)/(f_b−f_a).
    - Signed; the product is 2*WIDTH+2 bits; truncation toward zero.
    - Sequential restoring divider on magnitudes, sign fixed afterwards. Takes exactly 2*WIDTH+1 cycles in DIV.
    - If f_b==f_a (zero denominator), the divider is skipped; see Optional Feature.
  - UPDATE: c = b − q, clamped to [0, 2**WIDTH−1]. Then a<=b, f_a<=f_b, b<=c, iter_count+=1.
    - If c==b (no progress), go to FINISH with fail.
    - Otherwise go to SET_B, which measures the new b.
  - FINISH: done=1 for one cycle, busy=0, i_ref held at the last applied value. Go to IDLE.
- Measurement handshake:
  - meas_valid is sampled only in WAIT_*. Outside WAIT_* it is ignored.
  - meas_valid in the same cycle as ref_valid is not accepted; the earliest accept is the cycle after.
  - No timeout; the wait is unbounded.
- Latency per iteration, excluding plant wait: SET_B 1 + WAIT ≥1 + CHECK 1 + DIV 2*WIDTH+1 + UPDATE 1.
- A start pulse while busy=1 has no effect. A start in the same cycle as the done pulse is also ignored; IDLE accepts start from the next cycle.
- Reset mid-search immediately aborts and returns every output to its reset value.
- i_ref changes only in SET_* states and on reset.

Optional Feature:
- Macro: SECANT_BISECT_FALLBACK_EN.
- Defined: when f_b==f_a, or when the unclamped c falls outside [0, 2**WIDTH−1]:
  - Use c=(a+b)>>1, truncating.
  - The step still counts as an iteration.
  - The search fails only on MAX_ITER or on a no-progress step.
- Undefined:
  - f_b==f_a goes to FINISH with fail=1.
  - An out-of-range c is clamped as described in Behaviour.

Test Plan (WIDTH=10, TOL=30, MAX_ITER=8; the bench plant answers meas_valid 3 cycles after ref_valid):
- Linear plant m=i_ref/4+22, desired=200, init_a=0, init_b=1022:
  - f_a=−178, f_b=77, c=714.
  - Expect i_ref sequence 0, 1022, 714; converged=1, fail=0, iter_count=1, single done pulse.
- Same plant, desired=277, init_b=1022: f_b=0 at the first CHECK → converged, iter_count=0, no DIV cycles.
- Constant plant m=100, desired=200:
  - Macro undefined: fail=1, iter_count=0 immediately after WAIT_B.
  - Macro defined: i_ref visits 511, …; fail=1 with iter_count=8 (or fewer on no-progress).
- Plant m=i_ref/8, desired=1000 (unreachable): i_ref never exceeds 1023; fail=1; done pulses once.
- Assert rst=0 during the 2nd DIV:
  - Outputs go to reset values asynchronously and busy=0.
  - A new start after release runs a full search from SET_A.
- Pulse start during WAIT_B and pulse meas_valid during DIV: both ignored, and the i_ref sequence matches the undisturbed run.

Source files
------------

// File: rtl/secant_search.sv
// Secant-method search that drives i_ref until measured_q matches desired_q.
// Optional bisection fallback on a zero denominator or an out-of-range step: SECANT_BISECT_FALLBACK_EN.
module secant_search #(
    parameter int WIDTH    = 10,
    parameter int TOL      = 30,
    parameter int MAX_ITER = 8,
    parameter int ITW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] desired_q,
    input  logic [WIDTH-1:0] init_a,
    input  logic [WIDTH-1:0] init_b,
    input  logic [WIDTH-1:0] measured_q,
    input  logic             meas_valid,
    output logic [WIDTH-1:0] i_ref,
    output logic             ref_valid,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic             fail,
    output logic [ITW-1:0]   iter_count,
    output logic [3:0]       state_dbg
);

    localparam int EW  = WIDTH + 1;
    localparam int DW  = WIDTH + 2;
    localparam int PW  = 2 * WIDTH + 2;
    localparam int NW  = 2 * WIDTH + 1;
    localparam int CW  = 2 * WIDTH + 3;
    localparam int DCW = $clog2(NW);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SET_A  = 4'd1,
        S_WAIT_A = 4'd2,
        S_SET_B  = 4'd3,
        S_WAIT_B = 4'd4,
        S_CHECK  = 4'd5,
        S_DIV    = 4'd6,
        S_UPDATE = 4'd7,
        S_FINISH = 4'd8
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, dq_q, dq_d, iref_q, iref_d;
    logic signed [EW-1:0]   fa_q, fa_d, fb_q, fb_d;
    logic                   rv_q, rv_d, conv_q, conv_d, fail_q, fail_d, neg_q, neg_d;
    logic [ITW-1:0]         iter_q, iter_d;
    logic [NW-1:0]          num_q, num_d;
    logic [EW-1:0]          den_q, den_d, rem_q, rem_d;
    logic [DCW-1:0]         cnt_q, cnt_d;

    // Handshake: ref_valid pulses for one cycle with the new i_ref; a measurement is
    // accepted only in WAIT_* when meas_valid=1 and ref_valid is not high in that cycle.
    logic                   accept;
    logic signed [EW-1:0]   err, diff_ba;
    logic [EW-1:0]          abs_fb;
    logic                   fb_small, iter_max, den_zero;
    logic signed [PW-1:0]   prod;
    logic [PW-1:0]          prod_mag;
    logic signed [DW-1:0]   den_s;
    logic [DW-1:0]          den_mag;
    logic [EW:0]            rem_sh, rem_sub;
    logic                   sub_ok;
    logic signed [CW-1:0]   quot_ext, q_s, c_full;
    logic                   c_lo, c_hi, no_prog;
    logic [WIDTH-1:0]       c_clamp, c_next;
    logic                   unused_bits;

    assign accept   = meas_valid && !rv_q;
    assign err      = $signed({1'b0, measured_q}) - $signed({1'b0, dq_q});
    assign diff_ba  = $signed({1'b0, b_q}) - $signed({1'b0, a_q});
    assign abs_fb   = fb_q[EW-1] ? -fb_q : fb_q;
    assign fb_small = abs_fb < EW'(TOL);
    assign iter_max = iter_q == ITW'(MAX_ITER);
    assign den_zero = fb_q == fa_q;

    assign prod     = PW'(fb_q) * PW'(diff_ba);
    assign prod_mag = prod[PW-1] ? -prod : prod;
    assign den_s    = {fb_q[EW-1], fb_q} - {fa_q[EW-1], fa_q};
    assign den_mag  = den_s[DW-1] ? -den_s : den_s;

    // Restoring division: one quotient bit per cycle, quotient shifts into num_q.
    assign rem_sh   = {rem_q, num_q[NW-1]};
    assign sub_ok   = rem_sh >= {1'b0, den_q};
    assign rem_sub  = rem_sh - {1'b0, den_q};

    assign quot_ext = $signed(CW'(num_q));
    assign q_s      = neg_q ? -quot_ext : quot_ext;
    assign c_full   = $signed(CW'(b_q)) - q_s;
    assign c_lo     = c_full[CW-1];
    assign c_hi     = !c_lo && (|c_full[CW-2:WIDTH]);
    assign c_clamp  = c_lo ? '0 : (c_hi ? '1 : c_full[WIDTH-1:0]);

`ifdef SECANT_BISECT_FALLBACK_EN
    logic             bis_q, bis_d;
    logic [WIDTH:0]   mid_sum;
    logic             unused_mid;
    assign mid_sum    = {1'b0, a_q} + {1'b0, b_q};
    assign unused_mid = mid_sum[0];
    assign c_next     = (bis_q || c_lo || c_hi) ? mid_sum[WIDTH:1] : c_full[WIDTH-1:0];
`else
    assign c_next     = c_clamp;
`endif

    assign no_prog     = c_next == b_q;
    assign unused_bits = ^{prod_mag[PW-1], den_mag[DW-1], rem_sub[EW]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dq_q    <= '0;
            iref_q  <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            rv_q    <= 1'b0;
            conv_q  <= 1'b0;
            fail_q  <= 1'b0;
            neg_q   <= 1'b0;
            iter_q  <= '0;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
`ifdef SECANT_BISECT_FALLBACK_EN
            bis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dq_q    <= dq_d;
            iref_q  <= iref_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            rv_q    <= rv_d;
            conv_q  <= conv_d;
            fail_q  <= fail_d;
            neg_q   <= neg_d;
            iter_q  <= iter_d;
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
`ifdef SECANT_BISECT_FALLBACK_EN
            bis_q   <= bis_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SET_A;
            S_SET_A:  state_d = S_WAIT_A;
            S_WAIT_A: if (accept) state_d = S_SET_B;
            S_SET_B:  state_d = S_WAIT_B;
            S_WAIT_B: if (accept) state_d = S_CHECK;
            S_CHECK: begin
                if (fb_small || iter_max) begin
                    state_d = S_FINISH;
                end else if (den_zero) begin
`ifdef SECANT_BISECT_FALLBACK_EN
                    state_d = S_UPDATE;
`else
                    state_d = S_FINISH;
`endif
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DIV:    if (cnt_q == DCW'(NW - 1)) state_d = S_UPDATE;
            S_UPDATE: state_d = no_prog ? S_FINISH : S_SET_B;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        dq_d   = dq_q;
        iref_d = iref_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
        rv_d   = 1'b0;
        conv_d = conv_q;
        fail_d = fail_q;
        neg_d  = neg_q;
        iter_d = iter_q;
        num_d  = num_q;
        den_d  = den_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
`ifdef SECANT_BISECT_FALLBACK_EN
        bis_d  = bis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dq_d   = desired_q;
                    a_d    = init_a;
                    b_d    = init_b;
                    conv_d = 1'b0;
                    fail_d = 1'b0;
                    iter_d = '0;
                end
            end
            S_SET_A: begin
                iref_d = a_q;
                rv_d   = 1'b1;
            end
            S_WAIT_A: if (accept) fa_d = err;
            S_SET_B: begin
                iref_d = b_q;
                rv_d   = 1'b1;
            end
            S_WAIT_B: if (accept) fb_d = err;
            S_CHECK: begin
                if (fb_small) begin
                    conv_d = 1'b1;
                end else if (iter_max) begin
                    fail_d = 1'b1;
                end else if (den_zero) begin
`ifdef SECANT_BISECT_FALLBACK_EN
                    bis_d  = 1'b1;
`else
                    fail_d = 1'b1;
`endif
                end else begin
                    num_d = prod_mag[NW-1:0];
                    den_d = den_mag[EW-1:0];
                    rem_d = '0;
                    neg_d = prod[PW-1] ^ den_s[DW-1];
                    cnt_d = '0;
`ifdef SECANT_BISECT_FALLBACK_EN
                    bis_d = 1'b0;
`endif
                end
            end
            S_DIV: begin
                rem_d = sub_ok ? rem_sub[EW-1:0] : rem_sh[EW-1:0];
                num_d = {num_q[NW-2:0], sub_ok};
                cnt_d = cnt_q + 1'b1;
            end
            S_UPDATE: begin
                a_d    = b_q;
                fa_d   = fb_q;
                b_d    = c_next;
                iter_d = iter_q + 1'b1;
                if (no_prog) fail_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
        done       = state_q == S_FINISH;
        i_ref      = iref_q;
        ref_valid  = rv_q;
        converged  = conv_q;
        fail       = fail_q;
        iter_count = iter_q;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_secant_search.sv
// Bench for secant_search: delayed-response plant, model-driven i_ref scoreboard, scenario tasks.
module tb_secant_search;

  localparam int WIDTH    = 10;
  localparam int TOL      = 30;
  localparam int MAX_ITER = 8;
  localparam int ITW      = 4;
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_WAIT_B = 4'd4;
  localparam logic [3:0] ST_DIV    = 4'd6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] desired_q = '0;
  logic [WIDTH-1:0] init_a = '0;
  logic [WIDTH-1:0] init_b = '0;
  logic [WIDTH-1:0] measured_q = '0;
  logic             meas_valid = 1'b0;
  logic [WIDTH-1:0] i_ref;
  logic             ref_valid, busy, done, converged, fail;
  logic [ITW-1:0]   iter_count;
  logic [3:0]       state_dbg;

  secant_search #(.WIDTH(WIDTH), .TOL(TOL), .MAX_ITER(MAX_ITER), .ITW(ITW)) dut (
    .clk(clk), .rst(rst), .start(start), .desired_q(desired_q),
    .init_a(init_a), .init_b(init_b), .measured_q(measured_q), .meas_valid(meas_valid),
    .i_ref(i_ref), .ref_valid(ref_valid), .busy(busy), .done(done),
    .converged(converged), .fail(fail), .iter_count(iter_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  int done_cnt, div_entries, div_len;
  int plant_mode = 0;
  int pcnt = 0;
  bit disturb_en = 1'b0;
  bit inj_done = 1'b0;
  int e_conv, e_fail, e_iter, e_divs;
  logic [WIDTH-1:0] e_last;

  function automatic int plant_f(input int mode, input int i);
    case (mode)
      0: return i / 4 + 22;
      1: return 100;
      2: return i / 8;
      default: return (i * i) >> 10;
    endcase
  endfunction

  // Plant: answers 3 cycles after each ref_valid; optionally injects a stray meas_valid in DIV.
  always @(negedge clk) begin
    meas_valid = 1'b0;
    if (!rst) begin
      pcnt = 0;
    end else begin
      if (pcnt > 0) begin
        pcnt = pcnt - 1;
        if (pcnt == 0) begin
          meas_valid = 1'b1;
          measured_q = WIDTH'(plant_f(plant_mode, int'(i_ref)));
        end
      end
      if (ref_valid) pcnt = 3;
      if (disturb_en && state_dbg == ST_DIV && !inj_done) begin
        meas_valid = 1'b1;
        measured_q = '0;
        inj_done = 1'b1;
      end
      if (state_dbg == ST_IDLE) inj_done = 1'b0;
    end
  end

  task automatic model(input int mode, input int d, input int ia, input int ib);
    int a, b, fa, fb, q, c;
    bit bis;
    e_conv = 0; e_fail = 0; e_iter = 0; e_divs = 0;
    a = ia; b = ib;
    exp_q.push_back(WIDTH'(a)); fa = plant_f(mode, a) - d;
    exp_q.push_back(WIDTH'(b)); fb = plant_f(mode, b) - d;
    forever begin
      if ((fb < 0 ? -fb : fb) < TOL) begin e_conv = 1; break; end
      if (e_iter == MAX_ITER) begin e_fail = 1; break; end
      bis = 1'b0;
      if (fb == fa) begin
`ifdef SECANT_BISECT_FALLBACK_EN
        bis = 1'b1;
`else
        e_fail = 1;
        break;
`endif
      end
      if (!bis) begin
        e_divs++;
        q = (fb * (b - a)) / (fb - fa);
        c = b - q;
        if (c < 0 || c > (1 << WIDTH) - 1) begin
`ifdef SECANT_BISECT_FALLBACK_EN
          c = (a + b) / 2;
`else
          c = (c < 0) ? 0 : (1 << WIDTH) - 1;
`endif
        end
      end else begin
        c = (a + b) / 2;
      end
      e_iter++;
      a = b; fa = fb;
      if (c == b) begin e_fail = 1; break; end
      b = c;
      exp_q.push_back(WIDTH'(b)); fb = plant_f(mode, b) - d;
    end
    e_last = exp_q[exp_q.size() - 1];
  endtask

  // One clock step; also acts as the scoreboard monitor.
  task automatic step();
    logic [WIDTH-1:0] e;
    @(negedge clk);
    if (rst) begin
      if (ref_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_ref_valid i_ref=%0d", i_ref);
        end else begin
          e = exp_q.pop_front();
          if (i_ref !== e) begin errors++; $display("FAIL i_ref_seq got=%0d exp=%0d", i_ref, e); end
        end
      end
      if (done) done_cnt++;
      if (state_dbg == ST_DIV) begin
        if (div_len == 0) div_entries++;
        div_len++;
      end else if (div_len != 0) begin
        checks++;
        if (div_len != 2 * WIDTH + 1) begin errors++; $display("FAIL div_cycles got=%0d exp=%0d", div_len, 2 * WIDTH + 1); end
        div_len = 0;
      end
    end else begin
      div_len = 0;
    end
  endtask

  task automatic launch(input int mode, input int d, input int ia, input int ib);
    plant_mode = mode;
    desired_q = WIDTH'(d); init_a = WIDTH'(ia); init_b = WIDTH'(ib);
    exp_q.delete();
    model(mode, d, ia, ib);
    done_cnt = 0; div_entries = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit disturb, output bit ok);
    bit did_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step();
      start = 1'b0;
      if (disturb && state_dbg == ST_WAIT_B && !did_start) begin start = 1'b1; did_start = 1'b1; end
      if (done) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (i_ref !== '0) begin errors++; $display("FAIL rst_i_ref got=%0d exp=0", i_ref); end
    checks++; if ({ref_valid, busy, done, converged, fail} !== 5'b0) begin errors++; $display("FAIL rst_flags got=%b exp=00000", {ref_valid, busy, done, converged, fail}); end
    checks++; if (iter_count !== '0) begin errors++; $display("FAIL rst_iter got=%0d exp=0", iter_count); end
    rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_linear();
    bit ok;
    launch(0, 200, 0, 1022);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lin_timeout got=no_done exp=done"); end
    checks++; if (converged !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL lin_status got=%b%b exp=10", converged, fail); end
    checks++; if (iter_count !== 4'd1) begin errors++; $display("FAIL lin_iter got=%0d exp=1", iter_count); end
    checks++; if (i_ref !== 10'd714) begin errors++; $display("FAIL lin_final got=%0d exp=714", i_ref); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL lin_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lin_missing_refs got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_start_on_done();
    bit ok;
    launch(0, 277, 0, 1022);
    for (int i = 0; i < 5000 && !done; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    checks++; if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin errors++; $display("FAIL start_on_done got=busy%b st%0d exp=busy0 st0", busy, state_dbg); end
    checks++; if (converged !== 1'(e_conv) || iter_count !== ITW'(e_iter)) begin errors++; $display("FAIL exact_status got=c%b it%0d exp=c%0d it%0d", converged, iter_count, e_conv, e_iter); end
    checks++; if (div_entries != 0) begin errors++; $display("FAIL exact_no_div got=%0d exp=0", div_entries); end
    ok = exp_q.size() == 0;
    checks++; if (!ok) begin errors++; $display("FAIL exact_missing_refs got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_search(input int mode, input int d, input bit disturb);
    bit ok;
    disturb_en = disturb;
    launch(mode, d, 0, 1022);
    wait_done(disturb, ok);
    disturb_en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL m%0d_timeout got=no_done exp=done", mode); end
    checks++; if (converged !== 1'(e_conv) || fail !== 1'(e_fail)) begin errors++; $display("FAIL m%0d_status got=%b%b exp=%0d%0d", mode, converged, fail, e_conv, e_fail); end
    checks++; if (iter_count !== ITW'(e_iter)) begin errors++; $display("FAIL m%0d_iter got=%0d exp=%0d", mode, iter_count, e_iter); end
    checks++; if (i_ref !== e_last) begin errors++; $display("FAIL m%0d_final got=%0d exp=%0d", mode, i_ref, e_last); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL m%0d_done_cnt got=%0d exp=1", mode, done_cnt); end
    checks++; if (div_entries != e_divs) begin errors++; $display("FAIL m%0d_divs got=%0d exp=%0d", mode, div_entries, e_divs); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL m%0d_missing_refs got=%0d exp=0", mode, exp_q.size()); end
  endtask

  task automatic test_reset_mid_div();
    bit ok = 1'b0;
    launch(3, 500, 0, 1022);
    for (int i = 0; i < 5000; i++) begin
      step();
      if (div_entries == 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rdiv_reach got=no_2nd_div exp=2nd_div"); end
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    checks++; if (i_ref !== '0 || iter_count !== '0) begin errors++; $display("FAIL rdiv_regs got=%0d/%0d exp=0/0", i_ref, iter_count); end
    checks++; if ({ref_valid, busy, done, converged, fail} !== 5'b0) begin errors++; $display("FAIL rdiv_flags got=%b exp=00000", {ref_valid, busy, done, converged, fail}); end
    step();
    exp_q.delete();
    step();
    rst = 1'b1;
    step();
    test_search(3, 500, 1'b0);
  endtask

  initial begin
    test_reset();
    test_linear();
    test_start_on_done();
    test_search(1, 200, 1'b0);
    test_search(2, 1000, 1'b0);
    test_search(3, 500, 1'b0);
    test_reset_mid_div();
    test_search(3, 500, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
